// File: rtl/rv_pkg.sv
// Shared RV32I definitions for the decode stage.
//   - opcode constants for the supported base-ISA major opcodes
//   - alu_op_e: ALU operations, with branch compares folded into the same encoding space
//   - imm_sel_e: immediate format select for imm_gen
//   - id_ex_t: contents of the ID/EX pipeline register
//   - alu_from_funct3: funct3/alt-bit to ALU op for OP and OP_IMM
package rv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    // BLT/BLTU reuse the SLT/SLTU compares; only the remaining compares get their own codes.
    typedef enum logic [3:0] {
        AluAdd   = 4'd0,
        AluSub   = 4'd1,
        AluSll   = 4'd2,
        AluSlt   = 4'd3,
        AluSltu  = 4'd4,
        AluXor   = 4'd5,
        AluSrl   = 4'd6,
        AluSra   = 4'd7,
        AluOr    = 4'd8,
        AluAnd   = 4'd9,
        AluPassB = 4'd10,
        AluEq    = 4'd11,
        AluNe    = 4'd12,
        AluGe    = 4'd13,
        AluGeu   = 4'd14
    } alu_op_e;

    typedef enum logic [2:0] {
        ImmNone,
        ImmI,
        ImmS,
        ImmB,
        ImmU,
        ImmJ
    } imm_sel_e;

    typedef struct packed {
        logic             valid;
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  rs1_data;
        logic [XLEN-1:0]  rs2_data;
        logic [XLEN-1:0]  imm;
        logic [4:0]       rd;
        alu_op_e          alu_op;
        logic             src_a_pc;
        logic             src_b_imm;
        logic             mem_read;
        logic             mem_write;
        logic [2:0]       mem_size;
        logic             reg_write;
        logic             branch;
        logic             jump;
        logic             illegal;
    } id_ex_t;

    // alt selects SUB (funct3 000) or SRA (funct3 101); callers mask it where it must not apply.
    function automatic alu_op_e alu_from_funct3(input logic [2:0] funct3, input logic alt);
        alu_op_e op;
        unique case (funct3)
            3'b000:  op = alt ? AluSub : AluAdd;
            3'b001:  op = AluSll;
            3'b010:  op = AluSlt;
            3'b011:  op = AluSltu;
            3'b100:  op = AluXor;
            3'b101:  op = alt ? AluSra : AluSrl;
            3'b110:  op = AluOr;
            default: op = AluAnd;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: sign-extends the I/S/B/U/J immediate of an RV32I instruction.
//   instr_i    instruction word
//   imm_sel_i  immediate format
//   imm_o      32-bit immediate (0 for ImmNone)
module imm_gen
    import rv_pkg::*;
(
    input  logic [31:0] instr_i,
    input  imm_sel_e    imm_sel_i,
    output logic [31:0] imm_o
);

    // Opcode bits never contribute to an immediate.
    logic unused_opcode;
    assign unused_opcode = ^instr_i[6:0];

    always_comb begin
        imm_o = '0;
        unique case (imm_sel_i)
            ImmI: imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
            ImmS: imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            ImmB: imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                           instr_i[11:8], 1'b0};
            ImmU: imm_o = {instr_i[31:12], 12'b0};
            ImmJ: imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                           instr_i[30:21], 1'b0};
            default: imm_o = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I instruction decode stage with ID/EX pipeline register.
//   clk, rst                 clock, asynchronous active-high reset
//   instr_i, pc_i            instruction and its PC from fetch
//   flush_i                  redirect from EX; loads a bubble
//   rs1/rs2_addr_o, _data_i  register file read port (same-cycle data)
//   ex_rd_i, ex_mem_read_i   instruction in EX, for load-use detection
//   stall_o                  combinational load-use stall to fetch
//   remaining outputs        registered ID/EX contents
module decode_stage
    import rv_pkg::*;
#(
    parameter logic [31:0] BUBBLE_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    input  logic        flush_i,
    output logic [4:0]  rs1_addr_o,
    output logic [4:0]  rs2_addr_o,
    input  logic [31:0] rs1_data_i,
    input  logic [31:0] rs2_data_i,
    input  logic [4:0]  ex_rd_i,
    input  logic        ex_mem_read_i,
    output logic        stall_o,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] rs1_data_o,
    output logic [31:0] rs2_data_o,
    output logic [31:0] imm_o,
    output logic [4:0]  rd_o,
    output alu_op_e     alu_op_o,
    output logic        src_a_pc_o,
    output logic        src_b_imm_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic [2:0]  mem_size_o,
    output logic        reg_write_o,
    output logic        branch_o,
    output logic        jump_o,
    output logic        illegal_o
);

    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [2:0] funct3;
    logic [4:0] rs1, rs2, rd;

    assign opcode = instr_i[6:0];
    assign rd     = instr_i[11:7];
    assign funct3 = instr_i[14:12];
    assign rs1    = instr_i[19:15];
    assign rs2    = instr_i[24:20];
    assign funct7 = instr_i[31:25];

    assign rs1_addr_o = rs1;
    assign rs2_addr_o = rs2;

    logic        legal, uses_rs1, uses_rs2, has_rd;
    logic        src_a_pc, src_b_imm, mem_read, mem_write, branch, jump;
    alu_op_e     alu_op;
    imm_sel_e    imm_sel;
    logic [31:0] imm;
    logic        is_bubble;

    assign is_bubble = (instr_i == BUBBLE_INSTR);

    always_comb begin
        legal     = 1'b1;
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        has_rd    = 1'b0;
        src_a_pc  = 1'b0;
        src_b_imm = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        branch    = 1'b0;
        jump      = 1'b0;
        alu_op    = AluAdd;
        imm_sel   = ImmNone;
        case (opcode)
            OP: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                has_rd   = 1'b1;
                alu_op   = alu_from_funct3(funct3, instr_i[30]);
                legal    = (funct7 == 7'b0000000) ||
                           (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
            end
            OP_IMM: begin
                uses_rs1  = 1'b1;
                has_rd    = 1'b1;
                src_b_imm = 1'b1;
                imm_sel   = ImmI;
                // Only the right shift honours instr[30]; there is no SUBI.
                alu_op    = alu_from_funct3(funct3, instr_i[30] && funct3 == 3'b101);
                if (funct3 == 3'b001) begin
                    legal = (funct7 == 7'b0000000);
                end else if (funct3 == 3'b101) begin
                    legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                end
            end
            LOAD: begin
                uses_rs1  = 1'b1;
                has_rd    = 1'b1;
                src_b_imm = 1'b1;
                mem_read  = 1'b1;
                imm_sel   = ImmI;
                legal     = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
            end
            STORE: begin
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
                src_b_imm = 1'b1;
                mem_write = 1'b1;
                imm_sel   = ImmS;
                legal     = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
            end
            BRANCH: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                branch   = 1'b1;
                imm_sel  = ImmB;
                case (funct3)
                    3'b000:  alu_op = AluEq;
                    3'b001:  alu_op = AluNe;
                    3'b100:  alu_op = AluSlt;
                    3'b101:  alu_op = AluGe;
                    3'b110:  alu_op = AluSltu;
                    3'b111:  alu_op = AluGeu;
                    default: legal  = 1'b0;
                endcase
            end
            JAL: begin
                has_rd    = 1'b1;
                jump      = 1'b1;
                src_a_pc  = 1'b1;
                src_b_imm = 1'b1;
                imm_sel   = ImmJ;
            end
            JALR: begin
                uses_rs1  = 1'b1;
                has_rd    = 1'b1;
                jump      = 1'b1;
                src_b_imm = 1'b1;
                imm_sel   = ImmI;
                legal     = (funct3 == 3'b000);
            end
            LUI: begin
                has_rd    = 1'b1;
                src_b_imm = 1'b1;
                alu_op    = AluPassB;
                imm_sel   = ImmU;
            end
            AUIPC: begin
                has_rd    = 1'b1;
                src_a_pc  = 1'b1;
                src_b_imm = 1'b1;
                imm_sel   = ImmU;
            end
            default: legal = 1'b0;
        endcase
    end

    imm_gen u_imm_gen (
        .instr_i   (instr_i),
        .imm_sel_i (imm_sel),
        .imm_o     (imm)
    );

    // Illegal words never stall: they carry no register reads worth protecting.
    assign stall_o = !flush_i && ex_mem_read_i && (ex_rd_i != 5'd0) && legal && !is_bubble &&
                     ((uses_rs1 && rs1 == ex_rd_i) || (uses_rs2 && rs2 == ex_rd_i));

    id_ex_t id_ex_d, id_ex_q;

    always_comb begin
        id_ex_d = '0;
        if (!flush_i && !stall_o && !is_bubble) begin
            id_ex_d.valid    = 1'b1;
            id_ex_d.pc       = pc_i;
            id_ex_d.rs1_data = rs1_data_i;
            id_ex_d.rs2_data = rs2_data_i;
            id_ex_d.illegal  = !legal;
            if (legal) begin
                id_ex_d.imm       = imm;
                id_ex_d.rd        = has_rd ? rd : 5'd0;
                id_ex_d.alu_op    = alu_op;
                id_ex_d.src_a_pc  = src_a_pc;
                id_ex_d.src_b_imm = src_b_imm;
                id_ex_d.mem_read  = mem_read;
                id_ex_d.mem_write = mem_write;
                id_ex_d.mem_size  = (mem_read || mem_write) ? funct3 : 3'b000;
                id_ex_d.reg_write = has_rd && (rd != 5'd0);
                id_ex_d.branch    = branch;
                id_ex_d.jump      = jump;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_ex_q <= '0;
        end else begin
            id_ex_q <= id_ex_d;
        end
    end

    assign valid_o     = id_ex_q.valid;
    assign pc_o        = id_ex_q.pc;
    assign rs1_data_o  = id_ex_q.rs1_data;
    assign rs2_data_o  = id_ex_q.rs2_data;
    assign imm_o       = id_ex_q.imm;
    assign rd_o        = id_ex_q.rd;
    assign alu_op_o    = id_ex_q.alu_op;
    assign src_a_pc_o  = id_ex_q.src_a_pc;
    assign src_b_imm_o = id_ex_q.src_b_imm;
    assign mem_read_o  = id_ex_q.mem_read;
    assign mem_write_o = id_ex_q.mem_write;
    assign mem_size_o  = id_ex_q.mem_size;
    assign reg_write_o = id_ex_q.reg_write;
    assign branch_o    = id_ex_q.branch;
    assign jump_o      = id_ex_q.jump;
    assign illegal_o   = id_ex_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: hand-written vector table, reset sequences and random stimulus
// checked against a mask/match instruction-table model.
module tb_decode_stage;
    import rv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr_i, pc_i, rs1_data_i, rs2_data_i;
    logic        flush_i, ex_mem_read_i;
    logic [4:0]  ex_rd_i, rs1_addr_o, rs2_addr_o, rd_o;
    logic        stall_o, valid_o, src_a_pc_o, src_b_imm_o, mem_read_o, mem_write_o;
    logic        reg_write_o, branch_o, jump_o, illegal_o;
    logic [31:0] pc_o, rs1_data_o, rs2_data_o, imm_o;
    logic [2:0]  mem_size_o;
    alu_op_e     alu_op_o;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk           (clk),
        .rst           (rst),
        .instr_i       (instr_i),
        .pc_i          (pc_i),
        .flush_i       (flush_i),
        .rs1_addr_o    (rs1_addr_o),
        .rs2_addr_o    (rs2_addr_o),
        .rs1_data_i    (rs1_data_i),
        .rs2_data_i    (rs2_data_i),
        .ex_rd_i       (ex_rd_i),
        .ex_mem_read_i (ex_mem_read_i),
        .stall_o       (stall_o),
        .valid_o       (valid_o),
        .pc_o          (pc_o),
        .rs1_data_o    (rs1_data_o),
        .rs2_data_o    (rs2_data_o),
        .imm_o         (imm_o),
        .rd_o          (rd_o),
        .alu_op_o      (alu_op_o),
        .src_a_pc_o    (src_a_pc_o),
        .src_b_imm_o   (src_b_imm_o),
        .mem_read_o    (mem_read_o),
        .mem_write_o   (mem_write_o),
        .mem_size_o    (mem_size_o),
        .reg_write_o   (reg_write_o),
        .branch_o      (branch_o),
        .jump_o        (jump_o),
        .illegal_o     (illegal_o)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [159:0] got, input logic [159:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum int {KR, KI, KLD, KST, KBR, KJAL, KJALR, KLUI, KAUIPC} kind_e;

    typedef struct {
        logic [31:0] mask;
        logic [31:0] match;
        kind_e       kind;
        alu_op_e     alu;
    } dec_t;

    dec_t dec[$];

    typedef struct packed {
        logic        valid;
        logic [31:0] pc, d1, d2, imm;
        logic [4:0]  rd;
        logic [3:0]  alu;
        logic        a_pc, b_imm, mrd, mwr;
        logic [2:0]  msz;
        logic        rw, br, jp, ill;
    } exp_t;

    task automatic add(input logic [31:0] mask, input logic [31:0] match, input kind_e k,
                       input alu_op_e a);
        dec_t e;
        e.mask = mask;
        e.match = match;
        e.kind = k;
        e.alu = a;
        dec.push_back(e);
    endtask

    task automatic build_table();
        add(32'hFE00707F, 32'h00000033, KR, AluAdd);
        add(32'hFE00707F, 32'h40000033, KR, AluSub);
        add(32'hFE00707F, 32'h00001033, KR, AluSll);
        add(32'hFE00707F, 32'h00002033, KR, AluSlt);
        add(32'hFE00707F, 32'h00003033, KR, AluSltu);
        add(32'hFE00707F, 32'h00004033, KR, AluXor);
        add(32'hFE00707F, 32'h00005033, KR, AluSrl);
        add(32'hFE00707F, 32'h40005033, KR, AluSra);
        add(32'hFE00707F, 32'h00006033, KR, AluOr);
        add(32'hFE00707F, 32'h00007033, KR, AluAnd);
        add(32'h0000707F, 32'h00000013, KI, AluAdd);
        add(32'h0000707F, 32'h00002013, KI, AluSlt);
        add(32'h0000707F, 32'h00003013, KI, AluSltu);
        add(32'h0000707F, 32'h00004013, KI, AluXor);
        add(32'h0000707F, 32'h00006013, KI, AluOr);
        add(32'h0000707F, 32'h00007013, KI, AluAnd);
        add(32'hFE00707F, 32'h00001013, KI, AluSll);
        add(32'hFE00707F, 32'h00005013, KI, AluSrl);
        add(32'hFE00707F, 32'h40005013, KI, AluSra);
        add(32'h0000707F, 32'h00000003, KLD, AluAdd);
        add(32'h0000707F, 32'h00001003, KLD, AluAdd);
        add(32'h0000707F, 32'h00002003, KLD, AluAdd);
        add(32'h0000707F, 32'h00004003, KLD, AluAdd);
        add(32'h0000707F, 32'h00005003, KLD, AluAdd);
        add(32'h0000707F, 32'h00000023, KST, AluAdd);
        add(32'h0000707F, 32'h00001023, KST, AluAdd);
        add(32'h0000707F, 32'h00002023, KST, AluAdd);
        add(32'h0000707F, 32'h00000063, KBR, AluEq);
        add(32'h0000707F, 32'h00001063, KBR, AluNe);
        add(32'h0000707F, 32'h00004063, KBR, AluSlt);
        add(32'h0000707F, 32'h00005063, KBR, AluGe);
        add(32'h0000707F, 32'h00006063, KBR, AluSltu);
        add(32'h0000707F, 32'h00007063, KBR, AluGeu);
        add(32'h0000707F, 32'h00000067, KJALR, AluAdd);
        add(32'h0000007F, 32'h0000006F, KJAL, AluAdd);
        add(32'h0000007F, 32'h00000037, KLUI, AluPassB);
        add(32'h0000007F, 32'h00000017, KAUIPC, AluAdd);
    endtask

    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                   input logic [31:0] d1, input logic [31:0] d2,
                                   input logic fl, input logic [4:0] erd, input logic emr,
                                   output logic stall);
        exp_t e;
        int k;
        kind_e kd;
        logic u1, u2, wr;
        int v;
        logic signed [11:0] i12;
        logic signed [12:0] b13;
        logic signed [20:0] j21;
        e = '0;
        k = -1;
        stall = 1'b0;
        foreach (dec[i]) if ((ins & dec[i].mask) == dec[i].match) k = i;
        if (k < 0) begin
            if (!fl && ins != 32'h0) begin
                e.valid = 1'b1;
                e.ill = 1'b1;
                e.pc = pc;
                e.d1 = d1;
                e.d2 = d2;
            end
            return e;
        end
        kd = dec[k].kind;
        u1 = kd inside {KR, KI, KLD, KST, KBR, KJALR};
        u2 = kd inside {KR, KST, KBR};
        wr = kd inside {KR, KI, KLD, KJAL, KJALR, KLUI, KAUIPC};
        stall = !fl && emr && erd != 5'd0 &&
                ((u1 && ins[19:15] == erd) || (u2 && ins[24:20] == erd));
        if (fl || stall) return e;
        e.valid = 1'b1;
        e.pc = pc;
        e.d1 = d1;
        e.d2 = d2;
        e.alu = 4'(dec[k].alu);
        e.rd = wr ? ins[11:7] : 5'd0;
        e.rw = wr && ins[11:7] != 5'd0;
        e.a_pc = kd inside {KJAL, KAUIPC};
        e.b_imm = !(kd inside {KR, KBR});
        e.mrd = (kd == KLD);
        e.mwr = (kd == KST);
        e.msz = (kd inside {KLD, KST}) ? ins[14:12] : 3'b000;
        e.br = (kd == KBR);
        e.jp = kd inside {KJAL, KJALR};
        case (kd)
            KI, KLD, KJALR: begin i12 = $signed(ins[31:20]); v = i12; end
            KST: begin i12 = $signed({ins[31:25], ins[11:7]}); v = i12; end
            KBR: begin b13 = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}); v = b13; end
            KJAL: begin
                j21 = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
                v = j21;
            end
            KLUI, KAUIPC: v = int'(ins & 32'hFFFF_F000);
            default: v = 0;
        endcase
        e.imm = 32'(v);
        return e;
    endfunction

    function automatic exp_t actual();
        exp_t a;
        a = {valid_o, pc_o, rs1_data_o, rs2_data_o, imm_o, rd_o, 4'(alu_op_o), src_a_pc_o,
             src_b_imm_o, mem_read_o, mem_write_o, mem_size_o, reg_write_o, branch_o, jump_o,
             illegal_o};
        return a;
    endfunction

    // Drives one cycle of inputs (called at posedge+1), checks the combinational outputs,
    // then checks the registered result after the next edge.
    task automatic step(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                        input logic fl, input logic [4:0] erd, input logic emr);
        exp_t e;
        logic st;
        instr_i = ins;
        pc_i = pc;
        rs1_data_i = $urandom;
        rs2_data_i = $urandom;
        flush_i = fl;
        ex_rd_i = erd;
        ex_mem_read_i = emr;
        e = model(ins, pc, rs1_data_i, rs2_data_i, fl, erd, emr, st);
        #1;
        check({tag, " stall"}, 160'(stall_o), 160'(st));
        check({tag, " rs_addr"}, 160'({rs1_addr_o, rs2_addr_o}), 160'({ins[19:15], ins[24:20]}));
        @(posedge clk);
        #1;
        check({tag, " id_ex"}, 160'(actual()), 160'(e));
    endtask

    // ---------------- hand-written vectors ----------------
    typedef struct {
        logic [31:0] instr;
        logic [4:0]  ex_rd;
        logic        ex_mr;
        logic        flush;
        logic        st;
        logic        valid;
        logic [4:0]  rd;
        logic [31:0] imm;
        alu_op_e     alu;
        logic        rw, br, ill, bimm;
    } vec_t;

    vec_t vecs[$];

    task automatic vec(input logic [31:0] ins, input logic [4:0] erd, input logic emr,
                       input logic fl, input logic st, input logic vld, input logic [4:0] rd,
                       input logic [31:0] imm, input alu_op_e alu, input logic rw,
                       input logic br, input logic ill, input logic bimm);
        vec_t v;
        v.instr = ins; v.ex_rd = erd; v.ex_mr = emr; v.flush = fl; v.st = st; v.valid = vld;
        v.rd = rd; v.imm = imm; v.alu = alu; v.rw = rw; v.br = br; v.ill = ill; v.bimm = bimm;
        vecs.push_back(v);
    endtask

    initial begin
        build_table();
        //   instr         erd  emr fl  st vld rd  imm            alu       rw br il bi
        vec(32'hFFF10093, 5'd0,  0, 0, 0, 1, 5'd1, 32'hFFFFFFFF, AluAdd,   1, 0, 0, 1);
        vec(32'h006281B3, 5'd5,  1, 0, 1, 0, 5'd0, 32'h0,        AluAdd,   0, 0, 0, 0);
        vec(32'h006281B3, 5'd5,  0, 0, 0, 1, 5'd3, 32'h0,        AluAdd,   1, 0, 0, 0);
        vec(32'h006281B3, 5'd0,  1, 0, 0, 1, 5'd3, 32'h0,        AluAdd,   1, 0, 0, 0);
        vec(32'h006281B3, 5'd6,  1, 0, 1, 0, 5'd0, 32'h0,        AluAdd,   0, 0, 0, 0);
        vec(32'h006281B3, 5'd5,  1, 1, 0, 0, 5'd0, 32'h0,        AluAdd,   0, 0, 0, 0);
        vec(32'h123452B7, 5'd5,  1, 0, 0, 1, 5'd5, 32'h12345000, AluPassB, 1, 0, 0, 1);
        vec(32'hFE208EE3, 5'd0,  0, 0, 0, 1, 5'd0, 32'hFFFFFFFC, AluEq,    0, 1, 0, 0);
        vec(32'hFFFFFFFF, 5'd31, 1, 0, 0, 1, 5'd0, 32'h0,        AluAdd,   0, 0, 1, 0);
        vec(32'h00000000, 5'd0,  1, 0, 0, 0, 5'd0, 32'h0,        AluAdd,   0, 0, 0, 0);
        vec(32'hFFF10093, 5'd31, 1, 0, 0, 1, 5'd1, 32'hFFFFFFFF, AluAdd,   1, 0, 0, 1);
        vec(32'h000280EF, 5'd5,  1, 0, 0, 1, 5'd1, 32'h00028000, AluAdd,   1, 0, 0, 1);

        rst = 1'b1;
        instr_i = '0; pc_i = '0; rs1_data_i = '0; rs2_data_i = '0;
        flush_i = 1'b0; ex_rd_i = '0; ex_mem_read_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 160'(actual()), 160'(0));
        rst = 1'b0;

        foreach (vecs[i]) begin
            vec_t v;
            v = vecs[i];
            step($sformatf("vec%0d", i), v.instr, 32'h100 + 32'(4 * i), v.flush, v.ex_rd, v.ex_mr);
            check($sformatf("vec%0d stall_hand", i), 160'(stall_o), 160'(v.st));
            check($sformatf("vec%0d fields_hand", i),
                  160'({valid_o, rd_o, imm_o, 4'(alu_op_o), reg_write_o, branch_o, illegal_o,
                        src_b_imm_o}),
                  160'({v.valid, v.rd, v.imm, 4'(v.alu), v.rw, v.br, v.ill, v.bimm}));
        end

        // Reset asserted mid-stream with a valid entry held in ID/EX.
        step("pre_rst", 32'hFFF10093, 32'h200, 1'b0, 5'd0, 1'b0);
        check("pre_rst valid", 160'(valid_o), 160'(1));
        #2 rst = 1'b1;
        #1;
        check("async_rst", 160'(actual()), 160'(0));
        @(posedge clk);
        #1;
        check("rst_held", 160'(actual()), 160'(0));
        rst = 1'b0;
        step("post_rst", 32'hFFF10093, 32'h300, 1'b0, 5'd0, 1'b0);
        check("post_rst valid_rd", 160'({valid_o, rd_o}), 160'({1'b1, 5'd1}));

        // Random stimulus against the table model.
        for (int n = 0; n < 400; n++) begin
            logic [31:0] ins;
            logic [4:0]  erd;
            int          r, k;
            ins = $urandom;
            r = $urandom_range(0, 15);
            if (r == 0) begin
                ins = 32'h0;
            end else if (r > 1) begin
                k = $urandom_range(0, dec.size() - 1);
                ins = (ins & ~dec[k].mask) | dec[k].match;
            end
            case ($urandom_range(0, 2))
                0: erd = ins[19:15];
                1: erd = ins[24:20];
                default: erd = 5'($urandom_range(0, 31));
            endcase
            step("rand", ins, $urandom, ($urandom_range(0, 7) == 0), erd,
                 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
